alarm_countdown: RTL and testbench

Countdown timer feeding the six-digit alarm display decoder. Holds a 20-bit binary time value in 10 ms units (range 0..599999 = 99:59.99 MM:SS.cc), loads it from a setpoint, decrements it once per 10 ms tick while running, and raises an alarm when it reaches zero. Its `num` output connects directly to the decoder's `num` input; the decoder splits it by /10, /100, /1000 mod 6, /6000 and /60000.

---
 rtl/alarm_countdown_pkg.sv | 29 ++
 rtl/alarm_countdown_if.sv | 35 +++
 rtl/alarm_countdown_tick_gen.sv | 40 ++++
 rtl/alarm_countdown.sv | 133 +++++++++++++
 tb/tb_alarm_countdown.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_countdown_pkg.sv
//------------------------------------------------------------------------------
// Module   : alarm_pkg
// Brief    : Shared types, limits and helpers for the alarm countdown timer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alarm_pkg;

  localparam int CNT_W = 20;

  // 99:59.99 expressed in 10 ms units
  localparam logic [CNT_W-1:0] MAX_COUNT = 20'd599999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    ALARM  = 2'd3
  } state_t;

  // Clamp a setpoint to the largest value the display can show
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] v);
    return (v > MAX_COUNT) ? MAX_COUNT : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_countdown_if.sv
//------------------------------------------------------------------------------
// Module   : alarm_countdown_if
// Brief    : Command pulses and status outputs of the alarm countdown timer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alarm_countdown_if;
  import alarm_pkg::*;

  logic             load;
  logic [CNT_W-1:0] load_value;
  logic             start;
  logic             pause;
  logic             ack;
  logic [CNT_W-1:0] num;
  logic             running;
  logic             alarm;
  logic             blink;

  // Controller side: issues commands, observes the timer
  modport master (
    output load, load_value, start, pause, ack,
    input  num, running, alarm, blink
  );

  // Timer side
  modport slave (
    input  load, load_value, start, pause, ack,
    output num, running, alarm, blink
  );

endinterface

`default_nettype wire

// File: rtl/alarm_countdown_tick_gen.sv
//------------------------------------------------------------------------------
// Module   : tick_gen
// Brief    : Free-running clock divider producing a one-cycle tick strobe
//            every CLK_HZ/TICK_HZ cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  // Divider counts 0..DIV-1 and wraps; it never stops once out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Strobe is a pure decode of the divider register
  assign tick = (div_cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/alarm_countdown.sv
//------------------------------------------------------------------------------
// Module   : alarm_countdown
// Brief    : 10 ms countdown timer with setpoint, pause/resume and blinking
//            alarm; drives the six-digit alarm display decoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alarm_countdown
  import alarm_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 100,
  parameter int BLINK_TICKS = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  alarm_countdown_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_RUN    = RUN;
  localparam logic [1:0] S_PAUSED = PAUSED;
  localparam logic [1:0] S_ALARM  = ALARM;

  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic             tick;
  logic [1:0]       state,    state_nx;
  logic [CNT_W-1:0] num_q,    num_nx;
  logic [CNT_W-1:0] set_q,    set_nx;
  logic [BW-1:0]    bcnt_q,   bcnt_nx;
  logic             blink_q,  blink_nx;
  logic             running_q;
  logic             alarm_q;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Next-state logic; load outranks every other command where it applies
  always_comb begin
    state_nx = state;
    num_nx   = num_q;
    set_nx   = set_q;
    bcnt_nx  = bcnt_q;
    blink_nx = blink_q;
    if (bus.load && (state == S_IDLE || state == S_PAUSED)) begin
      num_nx   = sat_count(bus.load_value);
      set_nx   = sat_count(bus.load_value);
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && (num_q != '0)) begin
            state_nx = S_RUN;
          end
        end
        S_RUN: begin
          // A tick coinciding with pause still decrements before holding
          if (tick) begin
            num_nx = num_q - 1'b1;
            if (num_q == CNT_W'(1)) begin
              state_nx = S_ALARM;
              bcnt_nx  = '0;
              blink_nx = 1'b1;
            end else if (bus.pause) begin
              state_nx = S_PAUSED;
            end
          end else if (bus.pause) begin
            state_nx = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (bus.start) begin
            state_nx = S_RUN;
          end
        end
        S_ALARM: begin
          if (bus.ack) begin
            state_nx = S_IDLE;
            num_nx   = set_q;
            bcnt_nx  = '0;
            blink_nx = 1'b1;
          end else if (tick) begin
            if (bcnt_q == BLINK_LAST) begin
              bcnt_nx  = '0;
              blink_nx = ~blink_q;
            end else begin
              bcnt_nx = bcnt_q + 1'b1;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // State, count and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      num_q     <= '0;
      set_q     <= '0;
      bcnt_q    <= '0;
      blink_q   <= 1'b1;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      num_q     <= num_nx;
      set_q     <= set_nx;
      bcnt_q    <= bcnt_nx;
      blink_q   <= blink_nx;
      running_q <= (state_nx == S_RUN);
      alarm_q   <= (state_nx == S_ALARM);
    end
  end

  assign bus.num     = num_q;
  assign bus.running = running_q;
  assign bus.alarm   = alarm_q;
  assign bus.blink   = blink_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_countdown.sv
//------------------------------------------------------------------------------
// Module   : tb_alarm_countdown
// Brief    : Directed scenarios plus random command pulses, checked every
//            cycle against a behavioural timer model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alarm_countdown;
  import alarm_pkg::*;

  localparam int CLK_HZ      = 1000;
  localparam int TICK_HZ     = 100;
  localparam int BLINK_TICKS = 2;
  localparam int DIV         = CLK_HZ / TICK_HZ;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_ALARM  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alarm_countdown_if bus();

  alarm_countdown #(
    .CLK_HZ      (CLK_HZ),
    .TICK_HZ     (TICK_HZ),
    .BLINK_TICKS (BLINK_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: count, setpoint, mode, cycles since reset, ticks in alarm
  int m_num, m_set, m_mode, m_phase, m_at;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit tk;
    if (!rst_n) begin
      m_num = 0; m_set = 0; m_mode = M_IDLE; m_phase = 0; m_at = 0;
      return;
    end
    tk      = (m_phase == DIV - 1);
    m_phase = (m_phase + 1) % DIV;
    if (bus.load && (m_mode == M_IDLE || m_mode == M_PAUSED)) begin
      m_num  = (int'(bus.load_value) > 599999) ? 599999 : int'(bus.load_value);
      m_set  = m_num;
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE:   if (bus.start && m_num != 0) m_mode = M_RUN;
        M_RUN: begin
          if (tk) m_num = m_num - 1;
          if (m_num == 0) begin
            m_mode = M_ALARM;
            m_at   = 0;
          end else if (bus.pause) begin
            m_mode = M_PAUSED;
          end
        end
        M_PAUSED: if (bus.start) m_mode = M_RUN;
        default: begin
          if (bus.ack) begin
            m_mode = M_IDLE;
            m_num  = m_set;
          end else if (tk) begin
            m_at++;
          end
        end
      endcase
    end
  endtask

  function automatic bit m_blink();
    if (m_mode != M_ALARM) return 1'b1;
    return ((m_at / BLINK_TICKS) % 2) == 0;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("num",     bus.num,     m_num);
    check("running", bus.running, (m_mode == M_RUN));
    check("alarm",   bus.alarm,   (m_mode == M_ALARM));
    check("blink",   bus.blink,   m_blink());
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.ack   = 1'b0;
  endtask

  task automatic do_load(input int v);
    bus.load       = 1'b1;
    bus.load_value = v[19:0];
    step();
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
  endtask

  task automatic do_pause();
    bus.pause = 1'b1;
    step();
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_num(input string tag, input int target, input bit at_tick, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_num == target && (!at_tick || m_phase == DIV - 1)) break;
      step();
    end
    check(tag, bus.num, target);
  endtask

  task automatic run_until_alarm(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_mode == M_ALARM) break;
      step();
    end
    check(tag, bus.alarm, 1);
  endtask

  initial begin
    bus.load = 1'b0; bus.load_value = '0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.ack = 1'b0;
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;

    // Start with num=0 after reset is ignored
    do_start();
    check("start_zero_running", bus.running, 0);

    // Short countdown into alarm, then watch blink
    do_load(3);
    do_start();
    run_until_alarm("load3_alarm", 60);
    check("load3_num_zero", bus.num, 0);
    check("load3_not_running", bus.running, 0);
    run(60);
    do_ack();
    check("ack_num_setpoint", bus.num, 3);
    check("ack_blink", bus.blink, 1);

    // Saturating load and one decrement
    do_load(1_000_000);
    check("sat_load", bus.num, 599999);
    do_start();
    run_until_num("sat_first_tick", 599998, 1'b0, 15);
    do_load(5);
    check("load_in_run_ignored", bus.running, 1);

    // Pause hold and resume
    do_pause();
    do_load(100);
    do_start();
    run_until_num("reach95", 95, 1'b0, 80);
    do_pause();
    run(300);
    check("pause_hold", bus.num, 95);
    do_start();
    run(120);

    // Pause coinciding with a tick at num=50
    do_pause();
    do_load(60);
    do_start();
    run_until_num("reach50_at_tick", 50, 1'b1, 200);
    do_pause();
    check("pause_tick_num", bus.num, 49);
    check("pause_tick_running", bus.running, 0);
    run(25);
    do_load(7);
    check("load_in_pause", bus.num, 7);

    // Reset mid-run at num=40
    do_load(60);
    do_start();
    run_until_num("reach40", 40, 1'b0, 300);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_num", bus.num, 0);
    check("rst_running", bus.running, 0);
    check("rst_alarm", bus.alarm, 0);

    // Random command pulses, coincidences included
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        bus.load = 1'b1;
        if ($urandom_range(0, 3) == 0) bus.load_value = 20'($urandom);
        else bus.load_value = 20'($urandom_range(1, 25));
      end
      bus.start = ($urandom_range(0, 99) < 8);
      bus.pause = ($urandom_range(0, 99) < 3);
      bus.ack   = ($urandom_range(0, 99) < 4);
      rst_n     = ($urandom_range(0, 599) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
